// File: rtl/udp_tx_arb.sv
// udp_tx_arb: round-robin transmit scheduler between per-channel frame packers
// and the UDP transmit engine, with optional channel/sequence header word.
module udp_tx_arb #(
  parameter int CH_NUM      = 2,
  parameter int HDR_EN      = 1,
  parameter int IFG_CYC     = 12,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [CH_NUM-1:0]     ch_start_en,
  input  logic [16*CH_NUM-1:0]  ch_byte_num,
  input  logic [32*CH_NUM-1:0]  ch_data,
  output logic [CH_NUM-1:0]     ch_req,
  output logic [CH_NUM-1:0]     ch_done,
  output logic [CH_NUM-1:0]     ch_err,
  output logic                  tx_start_en,
  output logic [15:0]           tx_byte_num,
  output logic [31:0]           tx_data,
  input  logic                  tx_req,
  input  logic                  tx_done
);
  // state     | meaning
  // IDLE      | waiting for a pending channel, grant on the first one found
  // START     | one-cycle tx_start_en, arms the timeout
  // WAIT_DONE | steering tx_req/tx_data to the granted channel
  // GAP       | inter-frame gap, IFG_CYC+1 cycles
  typedef enum logic [1:0] {IDLE, START, WAIT_DONE, GAP} state_t;

  localparam int GW   = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
  localparam int TMAX = (TIMEOUT_CYC > IFG_CYC) ? TIMEOUT_CYC : IFG_CYC;
  localparam int TW   = $clog2(TMAX + 1);

  state_t          state, state_nxt;
  logic [GW-1:0]   gnt, sel, cand;
  logic            sel_vld;
  int              idx;
  logic [CH_NUM-1:0] pend;
  logic [15:0]     len      [CH_NUM];
  logic [7:0]      seq      [CH_NUM];
  logic [15:0]     len_in   [CH_NUM];
  logic [31:0]     ch_word  [CH_NUM];
  logic [TW-1:0]   tmr;
  logic            hdr_pend, hdr_cyc, rd_vld;
  logic [31:0]     data_hold;

  always_comb begin
    for (int i = 0; i < CH_NUM; i++) begin
      len_in[i]  = ch_byte_num[16*i +: 16];
      ch_word[i] = ch_data[32*i +: 32];
    end
  end

  // gnt doubles as the round-robin pointer; walking down leaves the nearest hit above it
  always_comb begin
    sel_vld = 1'b0;
    sel     = gnt;
    idx     = 0;
    cand    = '0;
    for (int k = CH_NUM; k >= 1; k--) begin
      idx  = (int'(gnt) + k) % CH_NUM;
      cand = GW'(idx);
      if (pend[cand]) begin
        sel_vld = 1'b1;
        sel     = cand;
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    tx_start_en = 1'b0;
    ch_req      = '0;
    ch_done     = '0;
    ch_err      = '0;
    case (state)
      IDLE:  if (sel_vld) state_nxt = START;
      START: begin
        tx_start_en = 1'b1;
        state_nxt   = WAIT_DONE;
      end
      WAIT_DONE: begin
        ch_req[gnt] = tx_req && !hdr_pend;
        if (tx_done) begin
          ch_done[gnt] = 1'b1;
          state_nxt    = GAP;
        end else if (tmr == '0) begin
          ch_err[gnt] = 1'b1;
          state_nxt   = GAP;
        end
      end
      GAP:     if (tmr == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Data is valid the cycle after a consumed request; otherwise hold the last word
  assign tx_data = !rd_vld ? data_hold :
                   hdr_cyc ? {16'h5AA5, 8'(gnt), seq[gnt]} : ch_word[gnt];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      gnt         <= GW'(CH_NUM - 1);
      pend        <= '0;
      tmr         <= '0;
      hdr_pend    <= 1'b0;
      hdr_cyc     <= 1'b0;
      rd_vld      <= 1'b0;
      data_hold   <= '0;
      tx_byte_num <= '0;
      for (int i = 0; i < CH_NUM; i++) begin
        len[i] <= '0;
        seq[i] <= '0;
      end
    end else begin
      state <= state_nxt;
      for (int i = 0; i < CH_NUM; i++) begin
        if (ch_start_en[i] && !pend[i] && len_in[i] != 16'd0) begin
          pend[i] <= 1'b1;
          len[i]  <= len_in[i];
        end
      end
      if (state == IDLE && sel_vld) begin
        pend[sel]   <= 1'b0;
        gnt         <= sel;
        tx_byte_num <= (HDR_EN != 0) ? len[sel] + 16'd4 : len[sel];
      end
      case (state)
        START: tmr <= TW'(TIMEOUT_CYC - 1);
        WAIT_DONE: begin
          if (tx_done || tmr == '0) tmr <= TW'(IFG_CYC);
          else                      tmr <= tmr - TW'(1);
        end
        GAP:     if (tmr != '0) tmr <= tmr - TW'(1);
        default: ;
      endcase
      if (state == WAIT_DONE && tx_done) seq[gnt] <= seq[gnt] + 8'd1;
      if (state == START)                    hdr_pend <= (HDR_EN != 0);
      else if (state == WAIT_DONE && tx_req) hdr_pend <= 1'b0;
      hdr_cyc <= (state == WAIT_DONE) && tx_req && hdr_pend;
      rd_vld  <= (state == WAIT_DONE) && tx_req;
      if (rd_vld) data_hold <= tx_data;
    end
  end

endmodule

// File: tb/tb_udp_tx_arb.sv
// Directed bench for udp_tx_arb: header build (timeout 50, gap 12) and a
// header-less build (gap 0), checked against a queue of expected grants.
module tb_udp_tx_arb;
  localparam int CH = 2;

  typedef struct {
    int          ch;
    logic [15:0] bytes;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [CH-1:0]    a_start = '0, b_start = '0;
  logic [16*CH-1:0] a_bytes = '0, b_bytes = '0;
  logic [32*CH-1:0] a_data = '0, b_data = '0;
  logic [CH-1:0]    a_req, a_done, a_err, b_req, b_done, b_err;
  logic             a_tx_start, b_tx_start;
  logic [15:0]      a_tx_bytes, b_tx_bytes;
  logic [31:0]      a_tx_data, b_tx_data;
  logic             a_tx_req = 1'b0, a_tx_done = 1'b0;
  logic             b_tx_req = 1'b0, b_tx_done = 1'b0;

  udp_tx_arb #(.CH_NUM(CH), .HDR_EN(1), .IFG_CYC(12), .TIMEOUT_CYC(50)) dut_a (
    .clk(clk), .rst_n(rst_n), .ch_start_en(a_start), .ch_byte_num(a_bytes),
    .ch_data(a_data), .ch_req(a_req), .ch_done(a_done), .ch_err(a_err),
    .tx_start_en(a_tx_start), .tx_byte_num(a_tx_bytes), .tx_data(a_tx_data),
    .tx_req(a_tx_req), .tx_done(a_tx_done));

  udp_tx_arb #(.CH_NUM(CH), .HDR_EN(0), .IFG_CYC(0), .TIMEOUT_CYC(1000)) dut_b (
    .clk(clk), .rst_n(rst_n), .ch_start_en(b_start), .ch_byte_num(b_bytes),
    .ch_data(b_data), .ch_req(b_req), .ch_done(b_done), .ch_err(b_err),
    .tx_start_en(b_tx_start), .tx_byte_num(b_tx_bytes), .tx_data(b_tx_data),
    .tx_req(b_tx_req), .tx_done(b_tx_done));

  int   checks = 0;
  int   errors = 0;
  exp_t q_a[$];
  logic [7:0] seq_a [CH];
  int   t_pulse = 0;
  int   done_cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [CH-1:0] onehot(input int ch);
    return CH'(1 << ch);
  endfunction

  function automatic logic [31:0] pat(input int ch, input int k);
    return (ch == 0) ? 32'hA000_0000 + 32'(k) : 32'hB000_0000 + 32'(k);
  endfunction

  task automatic pulse_a(input logic [CH-1:0] mask, input int b0, input int b1);
    a_start = mask;
    a_bytes = {16'(b1), 16'(b0)};
    t_pulse = cyc;
    step();
    a_start = '0;
  endtask

  task automatic push_a(input int ch, input int bytes);
    exp_t e;
    e.ch    = ch;
    e.bytes = 16'(bytes);
    q_a.push_back(e);
  endtask

  task automatic wait_start(input bit use_b, output bit got);
    got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      if (use_b ? b_tx_start : a_tx_start) got = 1'b1;
      else step();
    end
  endtask

  // Pops one expected grant from the queue and runs a whole frame on DUT A.
  task automatic serve_a(input int nwords, input bit finish, input int gap_exp,
                         input int lat_exp, input int repulse);
    exp_t e;
    bit   got;
    int   t_start;
    if (q_a.size() == 0) begin
      chk("a_queue_nonempty", 32'(q_a.size()), 32'd1);
      return;
    end
    e = q_a.pop_front();
    wait_start(1'b0, got);
    chk("a_start_seen", 32'(got), 32'd1);
    if (!got) return;
    t_start = cyc;
    if (gap_exp > 0) chk("a_gap", 32'(t_start - done_cyc), 32'(gap_exp));
    if (lat_exp > 0) chk("a_latency", 32'(t_start - t_pulse), 32'(lat_exp));
    chk("a_byte_num", 32'(a_tx_bytes), 32'(e.bytes));
    step();
    chk("a_start_one_cycle", 32'(a_tx_start), 32'd0);
    if (repulse > 0) begin
      a_start[e.ch] = 1'b1;
      a_bytes[16*e.ch +: 16] = 16'(repulse);
      push_a(e.ch, repulse + 4);
    end
    a_tx_req = 1'b1;
    #1;
    chk("a_hdr_req_hidden", 32'(a_req), 32'd0);
    step();
    a_start  = '0;
    a_tx_req = 1'b0;
    #1;
    chk("a_hdr_word", a_tx_data, {16'h5AA5, 8'(e.ch), seq_a[e.ch]});
    for (int k = 0; k < nwords; k++) begin
      a_tx_req = 1'b1;
      a_data   = {pat(1, k), pat(0, k)};
      #1;
      chk("a_ch_req", 32'(a_req), 32'(onehot(e.ch)));
      step();
      a_tx_req = 1'b0;
      #1;
      chk("a_payload", a_tx_data, pat(e.ch, k));
    end
    if (finish) begin
      a_tx_done = 1'b1;
      #1;
      chk("a_ch_done", 32'(a_done), 32'(onehot(e.ch)));
      done_cyc = cyc;
      step();
      a_tx_done = 1'b0;
      seq_a[e.ch] = seq_a[e.ch] + 8'd1;
    end else begin
      got = 1'b0;
      for (int i = 0; i < 200 && !got; i++) begin
        if (a_err != '0) got = 1'b1;
        else step();
      end
      chk("a_timeout_seen", 32'(got), 32'd1);
      chk("a_ch_err", 32'(a_err), 32'(onehot(e.ch)));
      chk("a_timeout_cyc", 32'(cyc - t_start), 32'd50);
      chk("a_err_no_done", 32'(a_done), 32'd0);
      done_cyc = cyc;
      step();
    end
  endtask

  task automatic expect_no_start_a(input string tag, input int ncyc);
    bit seen = 1'b0;
    for (int i = 0; i < ncyc; i++) begin
      if (a_tx_start) seen = 1'b1;
      step();
    end
    chk(tag, 32'(seen), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    int m;
    for (int i = 0; i < CH; i++) seq_a[i] = 8'd0;
    repeat (3) step();
    chk("rst_a_ctrl", {a_tx_start, a_req, a_done, a_err}, 32'd0);
    chk("rst_a_bytes", 32'(a_tx_bytes), 32'd0);
    chk("rst_a_data", a_tx_data, 32'd0);
    chk("rst_b_all", {b_tx_start, b_req, b_done, b_err, b_tx_bytes}, 32'd0);
    rst_n = 1'b1;
    step();

    // single frame, then a second frame of the same channel (sequence 1, gap 15)
    pulse_a(2'b01, 100, 0); push_a(0, 104);
    serve_a(25, 1'b1, 0, 2, 0);
    pulse_a(2'b01, 100, 0); push_a(0, 104);
    serve_a(2, 1'b1, 15, 0, 0);

    // round-robin from last=0: ch1 first; after ch1, ch0 first
    pulse_a(2'b11, 20, 40); push_a(1, 44); push_a(0, 24);
    serve_a(1, 1'b1, 15, 0, 0);
    serve_a(1, 1'b1, 15, 0, 0);
    pulse_a(2'b10, 0, 8); push_a(1, 12);
    serve_a(1, 1'b1, 15, 0, 0);
    pulse_a(2'b11, 16, 24); push_a(0, 20); push_a(1, 28);
    serve_a(1, 1'b1, 15, 0, 0);
    serve_a(1, 1'b1, 15, 0, 0);

    // timeout on ch0, ch1 still served, ch0 sequence unchanged afterwards
    pulse_a(2'b11, 12, 12); push_a(0, 16); push_a(1, 16);
    serve_a(3, 1'b0, 15, 0, 0);
    serve_a(1, 1'b1, 15, 0, 0);
    pulse_a(2'b01, 12, 0); push_a(0, 16);
    serve_a(1, 1'b1, 15, 0, 0);

    // duplicate pulse while pending keeps the first length
    pulse_a(2'b10, 0, 10); push_a(1, 14);
    pulse_a(2'b01, 30, 0); push_a(0, 34);
    pulse_a(2'b01, 50, 0);
    serve_a(1, 1'b1, 15, 0, 0);
    serve_a(1, 1'b1, 15, 0, 0);

    // pulse during the channel's own frame is the next frame
    pulse_a(2'b01, 36, 0); push_a(0, 40);
    serve_a(2, 1'b1, 15, 0, 40);
    serve_a(2, 1'b1, 15, 0, 0);

    pulse_a(2'b01, 0, 0);
    expect_no_start_a("a_zero_no_grant", 40);

    // reset mid-frame drops the frame and the pending ch1 request
    pulse_a(2'b01, 20, 0);
    wait_start(1'b0, got);
    chk("a_prereset_start", 32'(got), 32'd1);
    step();
    pulse_a(2'b10, 0, 10);
    a_tx_req = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    chk("a_midrst_outputs", {a_tx_start, a_req, a_done, a_err}, 32'd0);
    step();
    a_tx_req = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < CH; i++) seq_a[i] = 8'd0;
    expect_no_start_a("a_rst_drops_pend", 30);
    pulse_a(2'b01, 20, 0); push_a(0, 24);
    serve_a(1, 1'b1, 0, 2, 0);

    // header-less build: no hidden request, gap 0 gives m+3
    b_start = 2'b01; b_bytes = {16'd0, 16'd64}; t_pulse = cyc;
    step();
    b_start = '0;
    wait_start(1'b1, got);
    chk("b_start_seen", 32'(got), 32'd1);
    chk("b_latency", 32'(cyc - t_pulse), 32'd2);
    chk("b_byte_num", 32'(b_tx_bytes), 32'd64);
    step();
    b_tx_req = 1'b1;
    b_data = {pat(1, 5), pat(0, 5)};
    b_start = 2'b10; b_bytes = {16'd16, 16'd0};
    #1;
    chk("b_first_req_fwd", 32'(b_req), 32'(onehot(0)));
    step();
    b_tx_req = 1'b0;
    b_start = '0;
    #1;
    chk("b_payload0", b_tx_data, pat(0, 5));
    b_tx_done = 1'b1;
    #1;
    chk("b_ch_done0", 32'(b_done), 32'(onehot(0)));
    m = cyc;
    step();
    b_tx_done = 1'b0;
    b_tx_req = 1'b1;
    #1;
    chk("b_gap_req_ignored", 32'(b_req), 32'd0);
    b_tx_req = 1'b0;
    wait_start(1'b1, got);
    chk("b_start2_seen", 32'(got), 32'd1);
    chk("b_gap0", 32'(cyc - m), 32'd3);
    chk("b_byte_num2", 32'(b_tx_bytes), 32'd16);
    b_tx_req = 1'b1;
    #1;
    chk("b_start_req_ignored", 32'(b_req), 32'd0);
    step();
    b_data = {pat(1, 9), pat(0, 9)};
    #1;
    chk("b_data_hold", b_tx_data, pat(0, 5));
    chk("b_ch1_req", 32'(b_req), 32'(onehot(1)));
    step();
    b_tx_req = 1'b0;
    #1;
    chk("b_payload1", b_tx_data, pat(1, 9));
    b_tx_done = 1'b1;
    #1;
    chk("b_ch_done1", 32'(b_done), 32'(onehot(1)));
    step();
    b_tx_done = 1'b0;
    chk("a_queue_drained", 32'(q_a.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/udp_tx_arb.md
# udp_tx_arb

Multi-channel transmit scheduler that sits between the per-camera frame packers and the UDP transmit engine in the GMII transmit clock domain. It latches start requests from `CH_NUM` sources and grants them in round-robin order. Each grant produces one `tx_start_en`/`tx_byte_num` transaction toward the UDP transmitter, and the transmitter's word requests are steered back to the granted source. Optionally, every datagram is prefixed with a 4-byte header carrying the channel ID and a per-channel sequence number. An inter-frame gap and a completion timeout are also enforced.

## Interface
- `CH_NUM`, 2, number of source channels (2..8)
- `HDR_EN`, 1, 1 = prepend 32-bit header word to each datagram
- `IFG_CYC`, 12, idle cycles inserted after each `tx_done` before the next grant (0 allowed)
- `TIMEOUT_CYC`, 65535, maximum cycles between `tx_start_en` and `tx_done` before the frame is abandoned
- `clk` in 1 — GMII transmit clock; all logic is on this clock
- `rst_n` in 1 — asynchronous reset, active-low
- `ch_start_en` in CH_NUM — per-channel single-cycle start pulse
- `ch_byte_num` in 16*CH_NUM — per-channel payload byte count; channel i uses bits [16i+15:16i]; sampled with the start pulse
- `ch_data` in 32*CH_NUM — per-channel payload word; valid the cycle after the matching `ch_req`
- `ch_req` out CH_NUM — per-channel word read strobe
- `ch_done` out CH_NUM — one-cycle pulse when the channel's frame completes
- `ch_err` out CH_NUM — one-cycle pulse when the channel's frame is abandoned on timeout
- `tx_start_en` out 1 — start pulse to the UDP transmitter
- `tx_byte_num` out 16 — datagram byte count to the UDP transmitter
- `tx_data` out 32 — datagram word to the UDP transmitter
- `tx_req` in 1 — word request from the UDP transmitter
- `tx_done` in 1 — frame-complete pulse from the UDP transmitter

## Operation
- **Pending latch.** Per channel: `ch_start_en[i]` with a nonzero byte count sets `pend[i]` and loads `len[i]`.
  - A pulse with byte count 0 is ignored.
  - A pulse while `pend[i]` is already set is ignored, and `len[i]` is unchanged.
  - `pend[i]` clears on grant, so a pulse arriving during the channel's own transfer is accepted as the next frame.
- **State machine.** States are IDLE, START, WAIT_DONE, GAP.
  - **IDLE:** if any `pend` bit is set, select the first set bit searching upward from `last+1` (mod `CH_NUM`). Load `gnt` with that channel, clear its `pend` bit, set `last=gnt`, and go to START.
  - **START:** `tx_start_en=1` for exactly one cycle, then go to WAIT_DONE. This pulse arms the timeout counter.
  - **WAIT_DONE:** on `tx_done`, pulse `ch_done[gnt]` and go to GAP. If the timeout counter reaches `TIMEOUT_CYC` first, pulse `ch_err[gnt]` and go to GAP.
  - **GAP:** count `IFG_CYC` cycles, then go to IDLE. With `IFG_CYC=0`, GAP lasts 1 cycle.
- **Byte count.** `tx_byte_num` is registered at grant as `len[gnt]+4` when `HDR_EN=1`, otherwise `len[gnt]`. The sum wraps modulo 2^16; sources keep payloads ≤ 65531 bytes. The value is held until the next grant.
- **Header (`HDR_EN=1`).**
  - The first `tx_req` after `tx_start_en` is consumed internally and is not forwarded.
  - On the following cycle, `tx_data` = {16'h5AA5, 8'(gnt), `seq[gnt]`}.
  - `seq[gnt]` increments (8-bit wrap) on `ch_done`. It does not increment on `ch_err`.
- **Payload.**
  - `ch_req[gnt] = tx_req` for all subsequent requests while in WAIT_DONE.
  - `tx_data = ch_data[gnt]` except in the header cycle.
  - `ch_req` is 0 for non-granted channels and in every other state.
- **`tx_req` outside WAIT_DONE** is ignored, and `tx_data` holds its last value.

## Timing
- **Reset values:** all outputs are 0, state IDLE, `pend`=0, `seq`=0, `last`=`CH_NUM-1` (so channel 0 wins first).
- **Start latency:** a `ch_start_en` in cycle n, with all logic idle, sets `pend` at edge n+1. The grant happens in cycle n+1 and `tx_start_en` is high in cycle n+2.
- **Request path:** `ch_req` follows `tx_req` combinationally (0 cycles). Data returns 1 cycle later through a combinational mux on registered `gnt` and the registered header-phase flag.
- **Frame-to-frame:** `tx_done` in cycle m → next `tx_start_en` no earlier than m+`IFG_CYC`+3.
- **Reset mid-frame:** returns immediately to IDLE and drops all pending requests.

## Test plan
- **Single frame:** CH_NUM=2, HDR_EN=1. Pulse `ch_start_en[0]` with 100 bytes → `tx_start_en` 2 cycles later with `tx_byte_num`=104. First word is 32'h5AA5_0000. Next 25 `tx_req` pulses map to `ch_req[0]`. `tx_done` → `ch_done[0]` pulse. A second frame's header reads 32'h5AA5_0001.
- **Round-robin:** both channels pulse in the same cycle → channel 0 is served, then channel 1. Re-pulse both → channel 0, then channel 1 again. `ch_req[1]` never rises during channel 0 frames.
- **Gap:** `IFG_CYC`=12. Measure from `tx_done` to the next `tx_start_en` → exactly 15 cycles when a request is pending.
- **Timeout:** `TIMEOUT_CYC`=50, never assert `tx_done` → `ch_err[gnt]` pulse 50 cycles after `tx_start_en`. `seq` is unchanged, and the next pending channel is granted.
- **Edge requests:**
  - Byte count 0 → no grant.
  - A duplicate pulse while pending keeps the original `len`.
  - A pulse during the channel's own WAIT_DONE → a second frame is issued after the gap.
- **No header:** HDR_EN=0, 64 bytes → `tx_byte_num`=64. First `tx_req` is forwarded to `ch_req`.
